instr_mem_loader: RTL and testbench

Serial-to-memory program loader: accepts a byte stream (one byte per `i_rx_valid` pulse, typically from the UART receiver) and packs each group of four bytes into a 32-bit big-endian word. It writes each word into the byte-addressed instruction memory at consecutive word addresses 0, 4, 8, …. It is the write-side initiator for the single-port instruction RAM and its 32-bit write port. Loading stops on a halt word or when memory is exhausted, and completion is reported to the debug/control unit.

---
 rtl/instr_mem_loader.sv | 170 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Packs a serial byte stream into 32-bit big-endian words and writes them to
// the instruction RAM at byte addresses 0, 4, 8, ... until a halt word is
// seen or the memory is full.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_start       one-cycle pulse, begins a new load at address 0 (IDLE/DONE only)
//   i_rx_data     received byte
//   i_rx_valid    one-cycle strobe qualifying i_rx_data
//   o_mem_we      one-cycle RAM write enable
//   o_mem_addr    byte address of the word being written (multiple of 4)
//   o_mem_data    word to write, [31:24] lands at addr, [7:0] at addr+3
//   o_busy        high while collecting bytes
//   o_done        high once the load has finished
//   o_overflow    memory filled without a halt word
//   o_word_count  words written in the current load, halt word included
module instr_mem_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [4*DATA_WIDTH-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [4*DATA_WIDTH-1:0] o_mem_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overflow,
  output logic [ADDR_WIDTH-2:0]   o_word_count
);

  localparam int unsigned WORD_W = 4 * DATA_WIDTH;
  localparam int unsigned ACC_W  = 3 * DATA_WIDTH;
  localparam int unsigned CNT_W  = ADDR_WIDTH - 1;

  // Byte address of the last word slot in memory.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  // Holds the last three bytes received; the fourth completes the word.
  logic [ACC_W-1:0]        acc_q, acc_d;
  // Word assembled on the 4th-byte edge, written on the following edge so
  // that the byte stream can keep shifting in without disturbing it.
  logic                    pend_q, pend_d;
  logic [WORD_W-1:0]       pend_word_q, pend_word_d;
  logic [ADDR_WIDTH-1:0]   word_addr_q, word_addr_d;

  logic                    we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_d;
  logic [WORD_W-1:0]       mem_data_d;
  logic                    busy_d;
  logic                    done_d;
  logic                    ovf_d;
  logic [CNT_W-1:0]        cnt_d;

  logic [WORD_W-1:0]       shifted_c;

  assign shifted_c = {acc_q, i_rx_data};

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_q;
    pend_d      = 1'b0;
    pend_word_d = pend_word_q;
    word_addr_d = word_addr_q;
    we_d        = 1'b0;
    mem_addr_d  = o_mem_addr;
    mem_data_d  = o_mem_data;
    done_d      = o_done;
    ovf_d       = o_overflow;
    cnt_d       = o_word_count;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d     = S_RECV;
          byte_cnt_d  = 2'd0;
          acc_d       = '0;
          word_addr_d = '0;
          cnt_d       = '0;
          done_d      = 1'b0;
          ovf_d       = 1'b0;
        end
      end

      S_RECV: begin
        if (i_rx_valid) begin
          acc_d      = shifted_c[ACC_W-1:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            pend_d      = 1'b1;
            pend_word_d = shifted_c;
          end
        end

        // Write the completed word and decide whether the load ends here.
        if (pend_q) begin
          we_d        = 1'b1;
          mem_addr_d  = word_addr_q;
          mem_data_d  = pend_word_q;
          cnt_d       = o_word_count + CNT_W'(1);
          word_addr_d = word_addr_q + ADDR_WIDTH'(4);
          if (pend_word_q == HALT_WORD) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (word_addr_q == LAST_ADDR) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RECV);
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= 2'd0;
      acc_q        <= '0;
      pend_q       <= 1'b0;
      pend_word_q  <= '0;
      word_addr_q  <= '0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      acc_q        <= acc_d;
      pend_q       <= pend_d;
      pend_word_q  <= pend_word_d;
      word_addr_q  <= word_addr_d;
      o_mem_we     <= we_d;
      o_mem_addr   <= mem_addr_d;
      o_mem_data   <= mem_data_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_overflow   <= ovf_d;
      o_word_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: two instances (4 KiB and 16-byte memory) see
// the same stimulus; expected writes and flags come from a word-level model
// of the byte stream sent since the last start.
module tb_instr_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;

  logic        a_we, a_busy, a_done, a_ovf;
  logic [11:0] a_addr;
  logic [31:0] a_data;
  logic [10:0] a_cnt;

  logic        b_we, b_busy, b_done, b_ovf;
  logic [3:0]  b_addr;
  logic [31:0] b_data;
  logic [2:0]  b_cnt;

  instr_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .HALT_WORD(32'hFFFFFFFF)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_data(a_data), .o_busy(a_busy),
    .o_done(a_done), .o_overflow(a_ovf), .o_word_count(a_cnt)
  );

  instr_mem_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .HALT_WORD(32'hFFFFFFFF)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_data(b_data), .o_busy(b_busy),
    .o_done(b_done), .o_overflow(b_ovf), .o_word_count(b_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          dut;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t mon[$];
  int  sent_b[$];
  int  sent_t[$];
  int  cyc = 0;

  logic [7:0] ram_a [4096];
  logic [7:0] ram_b [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor plus a behavioural RAM for each instance.
  always @(negedge clk) begin : mon_blk
    wr_t w;
    if (a_we) begin
      w.dut = 0; w.addr = int'(a_addr); w.data = a_data; w.cyc = cyc;
      mon.push_back(w);
      ram_a[a_addr]         <= a_data[31:24];
      ram_a[a_addr + 12'd1] <= a_data[23:16];
      ram_a[a_addr + 12'd2] <= a_data[15:8];
      ram_a[a_addr + 12'd3] <= a_data[7:0];
    end
    if (b_we) begin
      w.dut = 1; w.addr = int'(b_addr); w.data = b_data; w.cyc = cyc;
      mon.push_back(w);
      ram_b[b_addr]        <= b_data[31:24];
      ram_b[b_addr + 4'd1] <= b_data[23:16];
      ram_b[b_addr + 4'd2] <= b_data[15:8];
      ram_b[b_addr + 4'd3] <= b_data[7:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input int b, input int gap);
    rx_valid = 1'b1;
    rx_data  = 8'(b);
    sent_b.push_back(b);
    sent_t.push_back(cyc + 1);
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(int'(w[31:24]), gap);
    send_byte(int'(w[23:16]), gap);
    send_byte(int'(w[15:8]),  gap);
    send_byte(int'(w[7:0]),   gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Start a fresh load (both instances must be in IDLE or DONE).
  task automatic start_load(input string name);
    mon.delete();
    sent_b.delete();
    sent_t.delete();
    pulse_start();
    chk({name, ".a_busy0"}, 64'(a_busy), 64'd1);
    chk({name, ".a_done0"}, 64'(a_done), 64'd0);
    chk({name, ".a_ovf0"},  64'(a_ovf),  64'd0);
    chk({name, ".a_cnt0"},  64'(a_cnt),  64'd0);
    chk({name, ".b_busy0"}, 64'(b_busy), 64'd1);
    chk({name, ".b_done0"}, 64'(b_done), 64'd0);
    chk({name, ".b_ovf0"},  64'(b_ovf),  64'd0);
    chk({name, ".b_cnt0"},  64'(b_cnt),  64'd0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, ".a_we"},   64'(a_we),   64'd0);
    chk({name, ".a_addr"}, 64'(a_addr), 64'd0);
    chk({name, ".a_data"}, 64'(a_data), 64'd0);
    chk({name, ".a_busy"}, 64'(a_busy), 64'd0);
    chk({name, ".a_done"}, 64'(a_done), 64'd0);
    chk({name, ".a_ovf"},  64'(a_ovf),  64'd0);
    chk({name, ".a_cnt"},  64'(a_cnt),  64'd0);
    chk({name, ".b_we"},   64'(b_we),   64'd0);
    chk({name, ".b_addr"}, 64'(b_addr), 64'd0);
    chk({name, ".b_data"}, 64'(b_data), 64'd0);
    chk({name, ".b_busy"}, 64'(b_busy), 64'd0);
    chk({name, ".b_done"}, 64'(b_done), 64'd0);
    chk({name, ".b_ovf"},  64'(b_ovf),  64'd0);
    chk({name, ".b_cnt"},  64'(b_cnt),  64'd0);
  endtask

  // Reset is asserted between edges; outputs must clear before the next edge.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check_reset_vals(name);
    tick();
    rst = 1'b0;
  endtask

  // Reference: group the bytes of this load into words, stop at a halt word
  // or at the last word slot, and expect each write one cycle after its
  // 4th byte is sampled.
  task automatic check_dut(input int d, input string name);
    int          aw;
    int          cap;
    int          n;
    int          nmin;
    logic [31:0] w;
    wr_t         e;
    wr_t         exp_q[$];
    wr_t         got_q[$];
    logic        e_done;
    logic        e_ovf;
    int          e_cnt;
    logic        g_we, g_busy, g_done, g_ovf;
    int          g_cnt;
    aw     = (d == 0) ? 12 : 4;
    cap    = 1 << (aw - 2);
    n      = sent_b.size();
    e_done = 1'b0;
    e_ovf  = 1'b0;
    e_cnt  = 0;
    for (int k = 0; 4 * k + 3 < n; k++) begin
      w = {8'(sent_b[4*k]), 8'(sent_b[4*k+1]), 8'(sent_b[4*k+2]), 8'(sent_b[4*k+3])};
      e.dut = d; e.addr = 4 * k; e.data = w; e.cyc = sent_t[4*k+3] + 1;
      exp_q.push_back(e);
      e_cnt++;
      if (w == 32'hFFFFFFFF) begin
        e_done = 1'b1;
        break;
      end
      if (k == cap - 1) begin
        e_done = 1'b1;
        e_ovf  = 1'b1;
        break;
      end
    end
    foreach (mon[i]) if (mon[i].dut == d) got_q.push_back(mon[i]);
    chk($sformatf("%s.d%0d.nwr", name, d), 64'(got_q.size()), 64'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("%s.d%0d.addr%0d", name, d, i), 64'(got_q[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s.d%0d.data%0d", name, d, i), 64'(got_q[i].data), 64'(exp_q[i].data));
      chk($sformatf("%s.d%0d.cyc%0d",  name, d, i), 64'(got_q[i].cyc),  64'(exp_q[i].cyc));
    end
    if (d == 0) begin
      g_we = a_we; g_busy = a_busy; g_done = a_done; g_ovf = a_ovf; g_cnt = int'(a_cnt);
    end else begin
      g_we = b_we; g_busy = b_busy; g_done = b_done; g_ovf = b_ovf; g_cnt = int'(b_cnt);
    end
    chk($sformatf("%s.d%0d.done", name, d), 64'(g_done), 64'(e_done));
    chk($sformatf("%s.d%0d.ovf",  name, d), 64'(g_ovf),  64'(e_ovf));
    chk($sformatf("%s.d%0d.cnt",  name, d), 64'(g_cnt),  64'(e_cnt));
    chk($sformatf("%s.d%0d.busy", name, d), 64'(g_busy), 64'(!e_done));
    chk($sformatf("%s.d%0d.we",   name, d), 64'(g_we),   64'd0);
  endtask

  task automatic check_both(input string name);
    check_dut(0, name);
    check_dut(1, name);
  endtask

  task automatic settle_or_reset(input string name);
    if (!(a_done && b_done)) do_reset(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check_reset_vals("por");
    idle(2);
    rst = 1'b0;
    idle(2);

    // Three words ending with the halt word.
    start_load("t1");
    send_word(32'h01020304, 1);
    send_word(32'hAABBCCDD, 1);
    send_word(32'hFFFFFFFF, 1);
    idle(4);
    check_both("t1");
    chk("t1.ram0", 64'(ram_a[0]), 64'h01);
    chk("t1.ram3", 64'(ram_a[3]), 64'h04);
    chk("t1.ram8", 64'(ram_a[8]), 64'hFF);

    // Bytes in DONE are ignored, then a restart clears flags and writes @0.
    send_word(32'h55667788, 0);
    idle(3);
    check_both("t6a");
    start_load("t6");
    send_word(32'h0A0B0C0D, 0);
    idle(4);
    check_both("t6");
    chk("t6.ram0", 64'(ram_a[0]), 64'h0A);
    settle_or_reset("t6r");

    // Eight back-to-back bytes.
    start_load("t2");
    for (int i = 0; i < 8; i++) send_byte(8'h11 + i, 0);
    idle(4);
    check_both("t2");
    settle_or_reset("t2r");

    // i_start mid-word is ignored.
    start_load("t3");
    send_byte(8'h21, 0);
    send_byte(8'h22, 1);
    pulse_start();
    send_byte(8'h23, 0);
    send_byte(8'h24, 0);
    idle(4);
    check_both("t3");
    settle_or_reset("t3r");

    // Reset after three bytes discards the partial word.
    start_load("t4");
    send_byte(8'h31, 0);
    send_byte(8'h32, 0);
    send_byte(8'h33, 0);
    do_reset("t4rst");
    idle(4);
    chk("t4.nowr", 64'(mon.size()), 64'd0);
    start_load("t4b");
    send_word(32'h41424344, 2);
    idle(4);
    check_both("t4b");
    settle_or_reset("t4r");

    // Five non-halt words: the 16-byte instance overflows after four.
    start_load("t5");
    for (int i = 0; i < 5; i++) send_word({8'(i), 24'h123456}, 0);
    idle(4);
    check_both("t5");
    settle_or_reset("t5r");

    // Randomized loads.
    for (int it = 0; it < 24; it++) begin
      int nw;
      int gap_max;
      start_load($sformatf("r%0d", it));
      nw      = $urandom_range(1, 6);
      gap_max = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          for (int j = 0; j < 4; j++) send_byte(8'hFF, $urandom_range(0, gap_max));
        end else begin
          for (int j = 0; j < 4; j++) send_byte($urandom_range(0, 255), $urandom_range(0, gap_max));
        end
      end
      for (int j = $urandom_range(0, 3); j > 0; j--) send_byte($urandom_range(0, 255), 0);
      idle(4);
      check_both($sformatf("r%0d", it));
      settle_or_reset($sformatf("r%0dr", it));
    end

    // Fill the whole 4 KiB memory: word count must reach 1024 without wrap.
    start_load("full");
    for (int i = 0; i < 4096; i++) send_byte($urandom_range(0, 254), 0);
    idle(4);
    check_both("full");
    settle_or_reset("fullr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
